// File: rtl/exc_vector_unit.sv
// Exception-entry / RTE sequencer: latches EPC and cause, fetches the vector byte
// from memory and requests the PC load through the PC-source mux.
module exc_vector_unit #(
    parameter int unsigned MEM_LATENCY = 1,
    parameter logic [7:0]  VEC_OPCODE  = 8'd253,
    parameter logic [7:0]  VEC_OVF     = 8'd254,
    parameter logic [7:0]  VEC_DIV0    = 8'd255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        exc_opcode,
    input  logic        exc_overflow,
    input  logic        exc_div0,
    input  logic        rte,
    input  logic [31:0] pc_in,
    input  logic [31:0] mem_data_in,
    output logic [31:0] mem_addr_out,
    output logic        mem_rd_req,
    output logic        busy,
    output logic [31:0] epcOut,
    output logic [31:0] vectorOut,
    output logic [1:0]  causeOut,
    output logic [2:0]  muxpcsource,
    output logic        pc_write
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_CAPTURE,
        S_WRITE,
        S_RET
    } state_e;

    localparam logic [2:0] WAIT_INIT = 3'(MEM_LATENCY - 1);

    state_e      state_q, state_d;
    logic [2:0]  wait_cnt_q, wait_cnt_d;
    logic [31:0] epc_q, epc_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] vector_q, vector_d;
    logic [1:0]  cause_q, cause_d;
    logic        exc_any;
    logic [7:0]  vec_sel;
    logic [1:0]  cause_sel;
    logic [7:0]  lane;

    assign exc_any = exc_opcode | exc_overflow | exc_div0;
    assign lane    = mem_data_in[{addr_q[1:0], 3'b000} +: 8];

    // Fixed priority among simultaneous requests: opcode > overflow > div0.
    always_comb begin
        cause_sel = 2'd3;
        vec_sel   = VEC_DIV0;
        if (exc_opcode) begin
            cause_sel = 2'd1;
            vec_sel   = VEC_OPCODE;
        end else if (exc_overflow) begin
            cause_sel = 2'd2;
            vec_sel   = VEC_OVF;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        case (state_q)
            S_IDLE: begin
                if (exc_any) begin
                    state_d = S_REQ;
                end else if (rte) begin
                    state_d = S_RET;
                end
            end
            S_REQ: begin
                if (MEM_LATENCY > 1) begin
                    state_d    = S_WAIT;
                    wait_cnt_d = WAIT_INIT;
                end else begin
                    state_d = S_CAPTURE;
                end
            end
            S_WAIT: begin
                wait_cnt_d = wait_cnt_q - 3'd1;
                if (wait_cnt_q == 3'd1) begin
                    state_d = S_CAPTURE;
                end
            end
            S_CAPTURE: state_d = S_WRITE;
            S_WRITE:   state_d = S_IDLE;
            S_RET:     state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy        = 1'b0;
        mem_rd_req  = 1'b0;
        pc_write    = 1'b0;
        muxpcsource = 3'd0;
        case (state_q)
            S_IDLE:    busy = 1'b0;
            S_REQ: begin
                busy       = 1'b1;
                mem_rd_req = 1'b1;
            end
            S_WAIT:    busy = 1'b1;
            S_CAPTURE: busy = 1'b1;
            S_WRITE: begin
                busy     = 1'b1;
                pc_write = 1'b1;
            end
            S_RET: begin
                busy        = 1'b1;
                pc_write    = 1'b1;
                muxpcsource = 3'd4;
            end
            default:   busy = 1'b0;
        endcase
    end

    // pc_in is only looked at on the IDLE->REQ edge; the cause survives until RET retires.
    always_comb begin
        epc_d    = epc_q;
        addr_d   = addr_q;
        vector_d = vector_q;
        cause_d  = cause_q;
        case (state_q)
            S_IDLE: begin
                if (exc_any) begin
                    epc_d   = pc_in - 32'd4;
                    cause_d = cause_sel;
                    addr_d  = {24'b0, vec_sel};
                end
            end
            S_CAPTURE: vector_d = {24'b0, lane};
            S_RET:     cause_d  = 2'd0;
            default:   epc_d    = epc_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wait_cnt_q <= 3'd0;
            epc_q      <= 32'd0;
            addr_q     <= 32'd0;
            vector_q   <= 32'd0;
            cause_q    <= 2'd0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
            epc_q      <= epc_d;
            addr_q     <= addr_d;
            vector_q   <= vector_d;
            cause_q    <= cause_d;
        end
    end

    assign mem_addr_out = addr_q;
    assign epcOut       = epc_q;
    assign vectorOut    = vector_q;
    assign causeOut     = cause_q;

endmodule

// File: tb/tb_exc_vector_unit.sv
// Scoreboard bench for exc_vector_unit: two instances (memory latency 1 and 3),
// each with a latency-accurate memory model; every PC load is matched to a queued expectation.
module tb_exc_vector_unit;

    localparam int          LAT0 = 1;
    localparam int          LAT1 = 3;
    localparam logic [31:0] GARB = 32'hDEAD_BEEF;

    typedef struct {
        int          dut;
        bit          is_ret;
        int          cyc;
        logic [31:0] epc;
        logic [31:0] cause;
        logic [31:0] vec;
        logic [31:0] addr;
    } ev_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        exc_op   [2];
    logic        exc_ov   [2];
    logic        exc_dz   [2];
    logic        rte_s    [2];
    logic [31:0] pc_s     [2];
    logic [31:0] mem_d    [2];
    logic [31:0] addr_o   [2];
    logic        rdreq    [2];
    logic        busy_o   [2];
    logic [31:0] epc_o    [2];
    logic [31:0] vec_o    [2];
    logic [1:0]  cause_o  [2];
    logic [2:0]  mux_o    [2];
    logic        pcw_o    [2];

    logic [31:0] mem_word [2];
    int          cd       [2];
    int          rd_cnt   [2];
    int          cyc = 0;
    int          total = 0;
    int          bad = 0;
    ev_t         sb_q [$];

    always #5 clk = ~clk;

    exc_vector_unit #(.MEM_LATENCY(LAT0)) u_dut0 (
        .clk(clk), .reset(reset),
        .exc_opcode(exc_op[0]), .exc_overflow(exc_ov[0]), .exc_div0(exc_dz[0]), .rte(rte_s[0]),
        .pc_in(pc_s[0]), .mem_data_in(mem_d[0]),
        .mem_addr_out(addr_o[0]), .mem_rd_req(rdreq[0]), .busy(busy_o[0]),
        .epcOut(epc_o[0]), .vectorOut(vec_o[0]), .causeOut(cause_o[0]),
        .muxpcsource(mux_o[0]), .pc_write(pcw_o[0])
    );

    exc_vector_unit #(.MEM_LATENCY(LAT1)) u_dut1 (
        .clk(clk), .reset(reset),
        .exc_opcode(exc_op[1]), .exc_overflow(exc_ov[1]), .exc_div0(exc_dz[1]), .rte(rte_s[1]),
        .pc_in(pc_s[1]), .mem_data_in(mem_d[1]),
        .mem_addr_out(addr_o[1]), .mem_rd_req(rdreq[1]), .busy(busy_o[1]),
        .epcOut(epc_o[1]), .vectorOut(vec_o[1]), .causeOut(cause_o[1]),
        .muxpcsource(mux_o[1]), .pc_write(pcw_o[1])
    );

    function automatic int lat_of(input int d);
        return (d == 0) ? LAT0 : LAT1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Memory model drives the word only during cycle REQ+latency; garbage otherwise.
    // The monitor pairs each pc_write with the oldest queued expectation.
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (cd[d] > 0) begin
                cd[d]    <= cd[d] - 1;
                mem_d[d] <= (cd[d] == 1) ? mem_word[d] : GARB;
            end else begin
                mem_d[d] <= GARB;
            end
            if (rdreq[d] === 1'b1) begin
                rd_cnt[d] <= rd_cnt[d] + 1;
                cd[d]     <= lat_of(d);
            end
            if (pcw_o[d] === 1'b1) begin
                if (sb_q.size() == 0) begin
                    chk($sformatf("spurious_pcw%0d", d), 32'd1, 32'd0);
                end else begin
                    ev_t e;
                    e = sb_q.pop_front();
                    chk("pcw_dut", d, e.dut);
                    chk("pcw_cycle", cyc, e.cyc);
                    chk("pcw_mux", {29'b0, mux_o[d]}, e.is_ret ? 32'd4 : 32'd0);
                    chk("pcw_epc", epc_o[d], e.epc);
                    chk("pcw_cause", {30'b0, cause_o[d]}, e.cause);
                    chk("pcw_vector", vec_o[d], e.vec);
                    chk("pcw_addr", addr_o[d], e.addr);
                    $display("txn dut=%0d kind=%s cyc=%0d epc=%h cause=%0d vec=%h mux=%0d",
                             d, e.is_ret ? "rte" : "exc", cyc, epc_o[d], cause_o[d], vec_o[d], mux_o[d]);
                end
            end
        end
    end

    task automatic pulse(input int d, input bit op, input bit ov, input bit dz, input bit r,
                         input logic [31:0] pc, output int c);
        @(negedge clk);
        exc_op[d] = op;
        exc_ov[d] = ov;
        exc_dz[d] = dz;
        rte_s[d]  = r;
        pc_s[d]   = pc;
        c = cyc;
        @(negedge clk);
        exc_op[d] = 1'b0;
        exc_ov[d] = 1'b0;
        exc_dz[d] = 1'b0;
        rte_s[d]  = 1'b0;
        pc_s[d]   = 32'h5555_0000;
    endtask

    task automatic push(input int d, input bit r, input int c, input logic [31:0] epc,
                        input logic [31:0] cause, input logic [31:0] vec, input logic [31:0] addr);
        ev_t e;
        e.dut = d; e.is_ret = r; e.cyc = c; e.epc = epc;
        e.cause = cause; e.vec = vec; e.addr = addr;
        sb_q.push_back(e);
    endtask

    task automatic check_zero(input int d);
        chk($sformatf("zero_epc%0d", d), epc_o[d], 32'd0);
        chk($sformatf("zero_vec%0d", d), vec_o[d], 32'd0);
        chk($sformatf("zero_cause%0d", d), {30'b0, cause_o[d]}, 32'd0);
        chk($sformatf("zero_addr%0d", d), addr_o[d], 32'd0);
        chk($sformatf("zero_rdreq%0d", d), {31'b0, rdreq[d]}, 32'd0);
        chk($sformatf("zero_busy%0d", d), {31'b0, busy_o[d]}, 32'd0);
        chk($sformatf("zero_pcw%0d", d), {31'b0, pcw_o[d]}, 32'd0);
        chk($sformatf("zero_mux%0d", d), {29'b0, mux_o[d]}, 32'd0);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int c;
        reset = 1'b1;
        for (int d = 0; d < 2; d++) begin
            exc_op[d] = 1'b0; exc_ov[d] = 1'b0; exc_dz[d] = 1'b0; rte_s[d] = 1'b0;
            pc_s[d] = 32'd0; mem_word[d] = GARB;
        end
        idle(3);
        reset = 1'b0;
        idle(5);
        check_zero(0);
        check_zero(1);

        // Overflow, latency 1, lane 2.
        mem_word[0] = 32'h00AB_0000;
        pulse(0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_0040, c);
        push(0, 1'b0, c + LAT0 + 2, 32'h0000_003C, 32'd2, 32'h0000_00AB, 32'd254);
        idle(6);

        // All three at once with PC wrap: opcode wins, lane 1.
        mem_word[0] = 32'h1122_3344;
        pulse(0, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0000_0000, c);
        push(0, 1'b0, c + LAT0 + 2, 32'hFFFF_FFFC, 32'd1, 32'h0000_0033, 32'd253);
        idle(6);

        // Div0, latency 3, lane 3; later opcode+rte while busy are dropped.
        mem_word[1] = 32'h5A00_0000;
        pulse(1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_1000, c);
        push(1, 1'b0, c + LAT1 + 2, 32'h0000_0FFC, 32'd3, 32'h0000_005A, 32'd255);
        pulse(1, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_2000, c);
        idle(8);
        chk("ignored_cause", {30'b0, cause_o[1]}, 32'd3);
        chk("ignored_epc", epc_o[1], 32'h0000_0FFC);
        chk("ignored_busy", {31'b0, busy_o[1]}, 32'd0);

        // RTE from IDLE: one-cycle response, cause clears after.
        pulse(1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_3000, c);
        push(1, 1'b1, c + 1, 32'h0000_0FFC, 32'd3, 32'h0000_005A, 32'd255);
        idle(2);
        chk("rte_cause_clr", {30'b0, cause_o[1]}, 32'd0);
        chk("rte_epc_hold", epc_o[1], 32'h0000_0FFC);

        // Reset while in WAIT aborts the sequence.
        pulse(1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_0080, c);
        @(negedge clk);
        chk("wait_busy", {31'b0, busy_o[1]}, 32'd1);
        reset = 1'b1;
        @(negedge clk);
        check_zero(1);
        reset = 1'b0;
        idle(6);

        // Fresh exception after the abort.
        mem_word[1] = 32'h0000_C300;
        pulse(1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0200, c);
        push(1, 1'b0, c + LAT1 + 2, 32'h0000_01FC, 32'd1, 32'h0000_00C3, 32'd253);
        idle(8);

        chk("sb_left", sb_q.size(), 32'd0);
        chk("rdreq_count0", rd_cnt[0], 32'd2);
        chk("rdreq_count1", rd_cnt[1], 32'd3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/exc_vector_unit.md
Name: exc_vector_unit

Overview:
- Exception-entry and return sequencer for the multicycle CPU.
- Sits directly upstream of the PC-source mux. It produces the zero-extended vector byte on mux input 0 and the EPC value on mux input 4.
- It also drives the mux select and the PC write strobe while handling an exception or an RTE.
- The main control FSM stalls while busy is high.

Parameters:
- MEM_LATENCY, 1, cycles from the mem_rd_req cycle until mem_data_in is valid (legal values 1..7)
- VEC_OPCODE, 253, byte address of the vector for an invalid opcode
- VEC_OVF, 254, byte address of the vector for arithmetic overflow
- VEC_DIV0, 255, byte address of the vector for divide by zero

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high reset
- exc_opcode  in  1  invalid-opcode exception request, 1-cycle pulse
- exc_overflow  in  1  ALU overflow exception request, 1-cycle pulse
- exc_div0  in  1  divide-by-zero exception request, 1-cycle pulse
- rte  in  1  return-from-exception request, 1-cycle pulse
- pc_in  in  32  current PC register value (already PC+4)
- mem_data_in  in  32  memory read word, little-endian
- mem_addr_out  out  32  byte address for the vector read
- mem_rd_req  out  1  memory read request
- busy  out  1  stall request to the main control
- epcOut  out  32  EPC register, to mux input 4
- vectorOut  out  32  zero-extended vector byte, to mux input 0
- causeOut  out  2  cause register: 0 none, 1 opcode, 2 overflow, 3 div0
- muxpcsource  out  3  PC-source select request: 3'd0 vector, 3'd4 EPC
- pc_write  out  1  PC load strobe, 1-cycle pulse

Behaviour:
- Reset (synchronous, active-high; forces IDLE from any state, including mid-sequence). All outputs and registers go to 0: epcOut, vectorOut, causeOut, mem_addr_out, mem_rd_req, busy, pc_write, muxpcsource.
- States: IDLE, REQ, WAIT, CAPTURE, WRITE, RET.
- IDLE:
  - busy=0, mem_rd_req=0, pc_write=0.
  - If any exc_* is high at a clock edge:
    - epcOut <= pc_in - 32'd4, wrapping modulo 2^32.
    - causeOut is latched by priority: opcode > overflow > div0.
    - mem_addr_out <= matching VEC_* value, zero-extended.
    - Next state REQ.
  - Else if rte is high: next state RET.
  - An exception and rte in the same cycle: the exception wins and rte is discarded.
- REQ:
  - busy=1, mem_rd_req=1 for exactly this cycle.
  - Next state WAIT if MEM_LATENCY>1, else CAPTURE.
  - The WAIT counter loads MEM_LATENCY-1.
- WAIT:
  - busy=1, mem_rd_req=0.
  - The counter decrements each cycle; go to CAPTURE when it reaches 1.
- CAPTURE (cycle REQ+MEM_LATENCY):
  - vectorOut <= {24'b0, lane}, where lane = mem_data_in[8*mem_addr_out[1:0] +: 8].
  - Next state WRITE.
- WRITE:
  - busy=1, muxpcsource=3'd0, pc_write=1 for one cycle.
  - Next state IDLE.
- RET:
  - busy=1, muxpcsource=3'd4, pc_write=1 for one cycle.
  - epcOut and causeOut hold their values; causeOut clears to 0 on the following edge.
  - Next state IDLE.
- muxpcsource is 3'd0 in every state except RET.
- Latency: exception pulse to pc_write = MEM_LATENCY+2 cycles after the sampling edge. rte pulse to pc_write = 1 cycle.
- Exceptions and rte that arrive while busy=1 are ignored (no nesting, no queuing).
- Multiple simultaneous exc_* pulses: only the highest priority is recorded.
- epcOut, causeOut and vectorOut hold between events. causeOut clears only on RET completion or reset.
- pc_in is sampled only on the IDLE->REQ edge. Later changes to pc_in do not affect epcOut.

Test Plan:
- Reset, then idle for 5 cycles -> all outputs 0, busy=0, no pc_write.
- pc_in=32'h0000_0040, exc_overflow pulse, MEM_LATENCY=1, mem_data_in=32'h00AB_0000 -> expected response:
  - epcOut=32'h3C, causeOut=2, mem_addr_out=254, mem_rd_req high for 1 cycle.
  - vectorOut=32'hAB.
  - pc_write with muxpcsource=0 exactly 3 cycles after the pulse edge.
- exc_opcode, exc_overflow and exc_div0 pulsed together, pc_in=32'h0 -> expected response:
  - causeOut=1, mem_addr_out=253, lane 1 selected.
  - epcOut=32'hFFFF_FFFC (wrap).
- With MEM_LATENCY=3, exc_div0 pulse, then a second exc_opcode pulse and an rte pulse 2 cycles later -> expected response:
  - mem_data_in is sampled 3 cycles after REQ; lane 3 gives vectorOut=mem_data_in[31:24].
  - The second exception and the rte are ignored; causeOut stays 3.
- After the previous handling, rte pulse in IDLE -> expected response:
  - Next cycle: pc_write=1 and muxpcsource=4; epcOut is unchanged.
  - causeOut=0 afterwards.
- Reset asserted during WAIT -> expected response:
  - State returns to IDLE and all outputs are 0 on the next edge; no pc_write is emitted.
  - A fresh exception afterwards completes normally.
